// File: rtl/adc_result_spi.sv
// rtl/adc_result_spi.sv - multislope conversion result buffer served over a mode-0 SPI slave
//
// Captures the controller's up/down/run-down counts into a shadow buffer on each
// result_valid strobe and serves the latest result to an MCU as one frame:
//   {overrun, result_pending, seq[5:0], count_up, count_down, count_rundown}, MSB first.
// SPI is oversampled in the clk domain; SCK and CS_n pass through 3-flop synchronizers.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   result_valid         one-cycle capture strobe from the conversion controller
//   count_up/down/rundown  conversion counts, valid with result_valid
//   spi_clk, spi_cs_n    SPI SCK and chip select from the MCU (asynchronous)
//   spi_miso             serial data to the MCU
//   spi_miso_oe          MISO pad driver enable (active while CS_n is low)
//   result_pending       an unread result sits in the shadow buffer
//   overrun              sticky: a result was overwritten before being read
`timescale 1ns/1ps
module adc_result_spi #(
  parameter int WIDTH    = 32,
  parameter int SEQ_BITS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] count_up,
  input  logic [WIDTH-1:0] count_down,
  input  logic [WIDTH-1:0] count_rundown,
  input  logic             spi_clk,
  input  logic             spi_cs_n,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic             result_pending,
  output logic             overrun
);

  localparam int FRAME  = 8 + 3 * WIDTH;
  localparam int DATA_W = 3 * WIDTH;
  localparam int CNT_W  = $clog2(FRAME);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2:0]          cs_sync;
  logic [2:0]          sck_sync;
  logic [DATA_W-1:0]   shadow;
  logic [SEQ_BITS-1:0] seq;
  logic [FRAME-1:0]    shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [5:0]          seq_hdr;
  logic [7:0]          header;
  logic                cs_fall;
  logic                cs_rise;
  logic                sck_fall;
  logic                load_en;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Reset to the bus idle levels so that releasing reset
  // with the MCU idle never looks like an edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync  <= 3'b111;
      sck_sync <= 3'b000;
    end else begin
      cs_sync  <= {cs_sync[1:0], spi_cs_n};
      sck_sync <= {sck_sync[1:0], spi_clk};
    end
  end

  assign cs_fall  =  cs_sync[2] & ~cs_sync[1];
  assign cs_rise  = ~cs_sync[2] &  cs_sync[1];
  assign sck_fall =  sck_sync[2] & ~sck_sync[1];

  assign spi_miso_oe = ~cs_sync[2];

  // Header carries exactly 6 sequence bits whatever SEQ_BITS is.
  generate
    if (SEQ_BITS >= 6) begin : g_seq_trunc
      assign seq_hdr = seq[5:0];
    end else begin : g_seq_ext
      assign seq_hdr = {{(6 - SEQ_BITS){1'b0}}, seq};
    end
  endgenerate

  assign header = {overrun, result_pending, seq_hdr};

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        state_next = SHIFT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // CS deassertion aborts the frame from any state, including LOAD.
    if (cs_rise) begin
      state_next = IDLE;
      load_en    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift register and MISO. MISO is registered so the MCU sees a clean level
  // that only changes on our view of SCK falling.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      spi_miso <= 1'b0;
    end else if (cs_rise) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      spi_miso <= 1'b0;
    end else if (load_en) begin
      shreg    <= {header, shadow};
      bit_cnt  <= CNT_W'(FRAME - 1);
      spi_miso <= header[7];
    end else if (state == SHIFT && sck_fall) begin
      // Zero fill means clocking past the end of the frame yields zeros.
      shreg    <= {shreg[FRAME-2:0], 1'b0};
      spi_miso <= shreg[FRAME-2];
      bit_cnt  <= (bit_cnt == '0) ? '0 : bit_cnt - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture and status flags. A strobe coinciding with LOAD lands in the
  // shadow after LOAD has copied the old one, so it counts as a fresh unread
  // result rather than an overrun.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow         <= '0;
      seq            <= '0;
      result_pending <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (result_valid) begin
        shadow <= {count_up, count_down, count_rundown};
        seq    <= seq + SEQ_BITS'(1);
      end

      if (result_valid) begin
        result_pending <= 1'b1;
      end else if (load_en) begin
        result_pending <= 1'b0;
      end

      if (load_en) begin
        overrun <= 1'b0;
      end else if (result_valid && result_pending) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
